onbehave_resp_checker: RTL and testbench

- Response-side counterpart to the onBehave stimulus drivers. Receives each applied A/B/C/D vector and the DUT's F1/F2 outputs.
- Waits a settle interval, then compares the outputs against a loadable golden truth table. Counts mismatches and captures the first failure.
- Sits beside onBehave in self-test builds, so pass/fail is produced in hardware rather than by waveform inspection.

---
 rtl/onbehave_pkg.sv | 19 +
 rtl/onbehave_golden_tbl.sv | 29 ++
 rtl/onbehave_resp_checker.sv | 177 +++++++++++++++++
 tb/tb_onbehave_resp_checker.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onbehave_pkg.sv
// rtl/onbehave_pkg.sv - shared types and constants for the onBehave response checker
package onbehave_pkg;

    localparam int VEC_W     = 4;
    localparam int RESP_W    = 2;
    localparam int TBL_DEPTH = 1 << VEC_W;

    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [RESP_W-1:0] resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/onbehave_golden_tbl.sv
// rtl/onbehave_golden_tbl.sv - 16x2 golden truth table with clear, sync write, comb read
module onbehave_golden_tbl
    import onbehave_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we_i,
    input  vec_t  waddr_i,
    input  resp_t wdata_i,
    input  vec_t  raddr_i,
    output resp_t rdata_o
);

    resp_t mem_q [TBL_DEPTH];

    // Table storage: cleared on reset, one entry written per strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/onbehave_resp_checker.sv
// rtl/onbehave_resp_checker.sv - settles, samples and compares DUT responses against a golden table
module onbehave_resp_checker
    import onbehave_pkg::*;
#(
    parameter int NUM_VECTORS = 16,
    parameter int SETTLE_CYC  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tbl_we,
    input  logic [3:0]       tbl_addr,
    input  logic [1:0]       tbl_data,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [3:0]       vec_in,
    input  logic [1:0]       f_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_seen,
    output logic [3:0]       first_fail_vec,
    output logic [1:0]       first_fail_got,
    output logic [1:0]       first_fail_exp
);

    // Vector counter must be able to hold NUM_VECTORS itself (256 needs 9 bits)
    localparam int                 VCNT_W      = $clog2(NUM_VECTORS + 1);
    localparam logic [VCNT_W-1:0]  VCNT_LAST   = VCNT_W'(NUM_VECTORS);
    localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE_CYC);

    state_t             state_q, state_d;
    vec_t               vec_q, vec_d;
    resp_t              samp_q, samp_d;
    logic [3:0]         settle_q, settle_d;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               fail_seen_q, fail_seen_d;
    vec_t               ff_vec_q, ff_vec_d;
    resp_t              ff_got_q, ff_got_d;
    resp_t              ff_exp_q, ff_exp_d;
    logic               vec_ready_q, vec_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               tbl_wr_en;
    resp_t              exp_resp;

    // Table is only writable while no run is using it
    assign tbl_wr_en = tbl_we && ((state_q == IDLE) || (state_q == DONE));

    onbehave_golden_tbl u_tbl (
        .clk     (clk),
        .rst     (rst),
        .we_i    (tbl_wr_en),
        .waddr_i (tbl_addr),
        .wdata_i (tbl_data),
        .raddr_i (vec_q),
        .rdata_o (exp_resp)
    );

    // Next-state, result bookkeeping and registered output values
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        samp_d      = samp_q;
        settle_d    = settle_q;
        vcnt_d      = vcnt_q;
        err_d       = err_q;
        fail_seen_d = fail_seen_q;
        ff_vec_d    = ff_vec_q;
        ff_got_d    = ff_got_q;
        ff_exp_d    = ff_exp_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    vcnt_d      = '0;
                    err_d       = '0;
                    fail_seen_d = 1'b0;
                    ff_vec_d    = '0;
                    ff_got_d    = '0;
                    ff_exp_d    = '0;
                end
            end
            RUN: begin
                if (vec_valid) begin
                    vec_d    = vec_in;
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // f_in is captured on the edge SETTLE_CYC cycles after acceptance
                if (settle_q <= 4'd1) begin
                    samp_d  = f_in;
                    state_d = COMPARE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            COMPARE: begin
                if (samp_q != exp_resp) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        ff_vec_d    = vec_q;
                        ff_got_d    = samp_q;
                        ff_exp_d    = exp_resp;
                    end
                end
                vcnt_d  = vcnt_q + 1'b1;
                state_d = (vcnt_d == VCNT_LAST) ? DONE : RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vec_ready_d = (state_d == RUN);
        busy_d      = (state_d == RUN) || (state_d == SETTLE) || (state_d == COMPARE);
        done_d      = (state_d == DONE);
        pass_d      = (state_d == DONE) && (err_d == '0);
    end

    // State and result registers; reset abandons any run in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            samp_q      <= '0;
            settle_q    <= '0;
            vcnt_q      <= '0;
            err_q       <= '0;
            fail_seen_q <= 1'b0;
            ff_vec_q    <= '0;
            ff_got_q    <= '0;
            ff_exp_q    <= '0;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            samp_q      <= samp_d;
            settle_q    <= settle_d;
            vcnt_q      <= vcnt_d;
            err_q       <= err_d;
            fail_seen_q <= fail_seen_d;
            ff_vec_q    <= ff_vec_d;
            ff_got_q    <= ff_got_d;
            ff_exp_q    <= ff_exp_d;
            vec_ready_q <= vec_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_ready      = vec_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_got = ff_got_q;
    assign first_fail_exp = ff_exp_q;

endmodule

// File: tb/tb_onbehave_resp_checker.sv
// tb/tb_onbehave_resp_checker.sv - scoreboard bench for onbehave_resp_checker
module tb_onbehave_resp_checker;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_addr = '0;
    logic [1:0] tbl_data = '0;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec_in = '0;
    logic [1:0] f_in = '0;
    logic       s_start = 1'b0;
    logic       s_vec_valid = 1'b0;

    logic       vec_ready, busy, done, pass, fail_seen;
    logic [7:0] err_count;
    logic [3:0] ff_vec;
    logic [1:0] ff_got, ff_exp;

    logic       s_vec_ready, s_busy, s_done, s_pass, s_fail_seen;
    logic [7:0] s_err_count;
    logic [3:0] s_ff_vec;
    logic [1:0] s_ff_got, s_ff_exp;

    typedef struct packed {
        logic [3:0] vec;
        logic [1:0] got;
        logic [1:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    logic [1:0] m_tbl [16];
    int         m_err;
    bit         m_fs;
    logic [3:0] m_ffv;
    logic [1:0] m_ffg, m_ffe;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    onbehave_resp_checker #(.NUM_VECTORS(16), .SETTLE_CYC(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_in(vec_in),
        .f_in(f_in), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_seen(fail_seen), .first_fail_vec(ff_vec), .first_fail_got(ff_got),
        .first_fail_exp(ff_exp)
    );

    onbehave_resp_checker #(.NUM_VECTORS(256), .SETTLE_CYC(2), .CNT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .start(s_start), .vec_valid(s_vec_valid), .vec_ready(s_vec_ready), .vec_in(vec_in),
        .f_in(f_in), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
        .fail_seen(s_fail_seen), .first_fail_vec(s_ff_vec), .first_fail_got(s_ff_got),
        .first_fail_exp(s_ff_exp)
    );

    task automatic model_clear();
        m_err = 0;
        m_fs  = 1'b0;
        m_ffv = '0;
        m_ffg = '0;
        m_ffe = '0;
    endtask

    task automatic pulse_start(input bit sat);
        @(negedge clk);
        if (sat) s_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        start   = 1'b0;
        model_clear();
    endtask

    task automatic pop_check(input bit sat);
        sb_t e;
        logic [7:0] got_err;
        logic       got_fs;
        e = sb_q.pop_front();
        if (e.got != e.exp) begin
            if (m_err < 255) m_err++;
            if (!m_fs) begin
                m_fs  = 1'b1;
                m_ffv = e.vec;
                m_ffg = e.got;
                m_ffe = e.exp;
            end
        end
        got_err = sat ? s_err_count : err_count;
        got_fs  = sat ? s_fail_seen : fail_seen;
        n_total++;
        if (got_err !== 8'(m_err))
            $display("FAIL err_count vec=%h got=%h exp=%h", e.vec, got_err, 8'(m_err));
        else n_pass++;
        n_total++;
        if (got_fs !== m_fs)
            $display("FAIL fail_seen vec=%h got=%b exp=%b", e.vec, got_fs, m_fs);
        else n_pass++;
    endtask

    task automatic drive_vec(input bit sat, input logic [3:0] v, input logic [1:0] f);
        sb_t e;
        int  n;
        e.vec = v;
        e.got = f;
        e.exp = m_tbl[v];
        sb_q.push_back(e);
        @(negedge clk);
        vec_in = v;
        f_in   = f;
        if (sat) s_vec_valid = 1'b1; else vec_valid = 1'b1;
        n = 0;
        while (!(sat ? s_vec_ready : vec_ready) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vec_valid   = 1'b0;
        s_vec_valid = 1'b0;
        while (!((sat ? s_vec_ready : vec_ready) || (sat ? s_done : done)) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= TMO) $display("FAIL timeout vec=%h got=expired exp=result", v);
        else n_pass++;
        pop_check(sat);
    endtask

    task automatic check_done(input string name, input logic exp_pass, input logic [7:0] exp_err);
        n_total++;
        if ({done, busy, pass} !== {1'b1, 1'b0, exp_pass})
            $display("FAIL %s done/busy/pass got=%b%b%b exp=%b%b%b", name, done, busy, pass, 1'b1, 1'b0, exp_pass);
        else n_pass++;
        n_total++;
        if (err_count !== exp_err)
            $display("FAIL %s final err got=%h exp=%h", name, err_count, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({vec_ready, busy, done, pass, err_count, fail_seen, ff_vec, ff_got, ff_exp} !== 21'd0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {vec_ready, busy, done, pass, err_count, fail_seen, ff_vec, ff_got, ff_exp});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({vec_ready, busy, done} !== 3'b000)
            $display("FAIL idle_after_reset got=%b exp=000", {vec_ready, busy, done});
        else n_pass++;
        for (int i = 0; i < 16; i++) m_tbl[i] = 2'b00;
    endtask

    task automatic load_table();
        for (int a = 0; a < 16; a++) begin
            logic [3:0] av;
            av = 4'(a);
            @(negedge clk);
            tbl_we   = 1'b1;
            tbl_addr = av;
            tbl_data = {av[3] & av[2], av[1] | av[0]};
            m_tbl[a] = {av[3] & av[2], av[1] | av[0]};
        end
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic test_all_pass();
        pulse_start(1'b0);
        for (int v = 0; v < 16; v++) drive_vec(1'b0, 4'(v), m_tbl[v]);
        check_done("all_pass", 1'b1, 8'h00);
        n_total++;
        if (fail_seen !== 1'b0) $display("FAIL all_pass fail_seen got=%b exp=0", fail_seen);
        else n_pass++;
    endtask

    task automatic test_single_fail();
        pulse_start(1'b0);
        // write during RUN must be dropped; entry 0 stays 2'b00
        tbl_we   = 1'b1;
        tbl_addr = 4'h0;
        tbl_data = 2'b11;
        @(negedge clk);
        tbl_we = 1'b0;
        for (int v = 0; v < 16; v++) drive_vec(1'b0, 4'(v), (v == 5) ? 2'b11 : m_tbl[v]);
        check_done("single_fail", 1'b0, 8'h01);
        n_total++;
        if ({ff_vec, ff_got, ff_exp} !== {4'h5, 2'b11, 2'b01})
            $display("FAIL first_fail got=%h/%b/%b exp=5/11/01", ff_vec, ff_got, ff_exp);
        else n_pass++;
    endtask

    task automatic test_done_write_start();
        @(negedge clk);
        start    = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = 4'h3;
        tbl_data = 2'b11;
        m_tbl[3] = 2'b11;
        @(negedge clk);
        start  = 1'b0;
        tbl_we = 1'b0;
        model_clear();
        for (int v = 0; v < 16; v++) drive_vec(1'b0, 4'(v), m_tbl[v]);
        check_done("done_write_start", 1'b1, 8'h00);
    endtask

    task automatic test_settle_sample();
        sb_t e;
        logic [3:0] rdy_seq;
        pulse_start(1'b0);
        e.vec = 4'h7;
        e.got = 2'b01;
        e.exp = m_tbl[7];
        sb_q.push_back(e);
        vec_in    = 4'h7;
        f_in      = 2'b10;
        vec_valid = 1'b1;
        @(negedge clk);
        rdy_seq[0] = vec_ready;
        @(negedge clk);
        rdy_seq[1] = vec_ready;
        f_in = 2'b01;
        @(negedge clk);
        rdy_seq[2] = vec_ready;
        @(negedge clk);
        rdy_seq[3] = vec_ready;
        f_in      = 2'b11;
        vec_valid = 1'b0;
        n_total++;
        if (rdy_seq !== 4'b1000)
            $display("FAIL hold_valid ready_seq got=%b exp=1000", rdy_seq);
        else n_pass++;
        pop_check(1'b0);
        @(negedge clk);
        n_total++;
        if (err_count !== 8'h00) $display("FAIL late_change err got=%h exp=00", err_count);
        else n_pass++;
        for (int v = 0; v < 16; v++) if (v != 7) drive_vec(1'b0, 4'(v), m_tbl[v]);
        check_done("settle_sample", 1'b1, 8'h00);
    endtask

    task automatic test_reset_mid_settle();
        pulse_start(1'b0);
        vec_in    = 4'hF;
        f_in      = 2'b10;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL pre_reset busy got=%b exp=1", busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({vec_ready, busy, done, pass, err_count, fail_seen, ff_vec, ff_got, ff_exp} !== 21'd0)
            $display("FAIL mid_settle_reset got=%h exp=0",
                     {vec_ready, busy, done, pass, err_count, fail_seen, ff_vec, ff_got, ff_exp});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_tbl[i] = 2'b00;
        pulse_start(1'b0);
        drive_vec(1'b0, 4'hF, 2'b11);
        for (int v = 0; v < 15; v++) drive_vec(1'b0, 4'(v), 2'b00);
        check_done("cleared_table", 1'b0, 8'h01);
        n_total++;
        if ({ff_vec, ff_got, ff_exp} !== {4'hF, 2'b11, 2'b00})
            $display("FAIL cleared_first_fail got=%h/%b/%b exp=f/11/00", ff_vec, ff_got, ff_exp);
        else n_pass++;
    endtask

    task automatic test_saturate();
        pulse_start(1'b1);
        for (int i = 0; i < 256; i++) drive_vec(1'b1, 4'(i), 2'b11);
        n_total++;
        if ({s_done, s_pass, s_err_count} !== {1'b1, 1'b0, 8'hFF})
            $display("FAIL saturate done/pass/err got=%b%b/%h exp=10/ff", s_done, s_pass, s_err_count);
        else n_pass++;
        n_total++;
        if ({s_ff_vec, s_ff_got, s_ff_exp} !== {4'h0, 2'b11, 2'b00})
            $display("FAIL saturate first_fail got=%h/%b/%b exp=0/11/00", s_ff_vec, s_ff_got, s_ff_exp);
        else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        load_table();
        test_all_pass();
        test_single_fail();
        test_done_write_start();
        test_settle_sample();
        test_reset_mid_settle();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
